d1s4035_serial_rx: RTL

Serial receiver and evaluator for the d1s4035 three-input function. It accepts framed serial bits in the order start, a, b, c, stop, and registers the word {a,b,c}. It computes d = a & b & ~c, which is 1 only for 3'b110. It also keeps frame and hit statistics. The block is the consuming end of the link that carries d1s4035 input vectors serially: the stimulus side transmits the vectors, and this block reconstructs them and produces the function result in hardware.

---
 rtl/d1s4035_serial_rx.sv | 110 +++++++++++
 1 files changed

// File: rtl/d1s4035_serial_rx.sv
// Framed serial receiver for the d1s4035 function: collects {a,b,c} between start/stop bits,
// registers the word and d = a & b & ~c, and keeps good-frame and hit statistics.
module d1s4035_serial_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             clr_cnt,
    output logic [2:0]       abc,
    output logic             d,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] idx;
    logic [2:0] sh;
    logic       good_frame;

    function automatic logic eval_d(input logic [2:0] w);
        return w[2] & w[1] & ~w[0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // By the time STOP is reached, sh already holds the complete {a,b,c} word.
    assign good_frame = (state == STOP) && rx_valid && rx_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            sh          <= 3'b000;
            abc         <= 3'b000;
            d           <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid && !rx_bit) begin
                        state <= DATA;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        sh  <= {sh[1:0], rx_bit};
                        idx <= idx + 2'd1;
                        if (idx == 2'd2) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // A zero stop bit returns to IDLE without being taken as a new start bit.
                    if (rx_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_bit) begin
                            abc         <= sh;
                            d           <= eval_d(sh);
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a coinciding good frame; the word still updates above.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            hit_cnt   <= '0;
        end else if (clr_cnt) begin
            frame_cnt <= '0;
            hit_cnt   <= '0;
        end else if (good_frame) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            if (eval_d(sh)) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end

endmodule
